vga_sync: RTL and testbench
===========================

# vga_sync

Generates 640x480 @ 60 Hz VGA horizontal/vertical timing from the board's 50 MHz clock. It advances one pixel per pixel-enable strobe, normally the 25 MHz output of the clock divider. It sits directly downstream of the clock divider and upstream of the pixel/colour generator. That generator consumes `pixel_x`, `pixel_y` and `video_on` to produce RGB data, and this block drives `hsync`/`vsync` straight to the connector.

## Interface
Parameters (all counts in pixels or lines; every value below 1024):
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch

Derived values: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).

Ports:
- `clk`  in  1  board clock, 50 MHz; all flops on rising edge
- `clr`  in  1  reset, asynchronous, active-low
- `pix_en`  in  1  pixel advance strobe; sampled on `clk`; counters step only when high
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `video_on`  out  1  high while the current position is inside the visible area
- `pixel_x`  out  10  current column, 0..H_TOTAL-1
- `pixel_y`  out  10  current line, 0..V_TOTAL-1
- `line_start`  out  1  one-`clk` pulse when `pixel_x` becomes 0
- `frame_start`  out  1  one-`clk` pulse when the position becomes (0,0)

## Operation
- Two counters: h_cnt and v_cnt, each 10 bits unsigned. They drive `pixel_x`/`pixel_y` directly from flops.
- On a `clk` edge with `pix_en`=1:
  - h_cnt increments. When h_cnt = H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on an h_cnt wrap. When v_cnt = V_TOTAL-1 it wraps to 0 on the same edge.
- When `pix_en`=0, counters and all level outputs hold. `line_start`/`frame_start` return to 0.
- Every output is driven from a flop and is glitch-free. No combinational path exists from `pix_en` to any output.
- Each level output is a registered decode of the counter value it accompanies, updated on the same edge as the counters:
  - `hsync`=0 iff H_VIS+H_FP ≤ `pixel_x` ≤ H_VIS+H_FP+H_SYNC-1 (656..751)
  - `vsync`=0 iff V_VIS+V_FP ≤ `pixel_y` ≤ V_VIS+V_FP+V_SYNC-1 (490..491)
  - `video_on`=1 iff `pixel_x` < H_VIS and `pixel_y` < V_VIS
- `line_start`=1 for exactly the one `clk` cycle following the edge on which h_cnt wrapped to 0.
- `frame_start`=1 for the same cycle when v_cnt also wrapped to 0. `frame_start` implies `line_start`.
- `vsync` transitions are aligned with h_cnt = 0 (line boundaries), never mid-line.

## Timing
- Reset (`clr`=0), effective immediately and asynchronously:
  - h_cnt = H_TOTAL-1 (799), v_cnt = V_TOTAL-1 (524)
  - `hsync`=1, `vsync`=1, `video_on`=0, `line_start`=0, `frame_start`=0
- Reset position is the last pixel of the frame, so the first `pix_en` after reset release moves to (0,0). That edge raises `video_on`=1, `line_start`=1 and `frame_start`=1.
- Reset asserted mid-frame: outputs go to reset values without waiting for `clk`. Release restarts from the reset position; no partial-frame state survives.
- Latency: 0 `clk` from a counter value to its decoded `hsync`/`vsync`/`video_on`, because they update on the same edge.
- With the divider's 25 MHz square wave as `pix_en` (high every other `clk`):
  - one line = 1600 `clk` = 32 µs
  - one frame = 840 000 `clk` = 16.8 ms (≈59.5 Hz)
  - `line_start`/`frame_start` pulses are 1 `clk` (20 ns) wide
- `pix_en` held high continuously is legal: the block steps every `clk` and all rules above still hold.

## Test plan
- Reset then release; apply `pix_en` alternating 1/0:
  - first `pix_en` edge gives `pixel_x`=0, `pixel_y`=0, `video_on`=1, `frame_start`=1 for 1 `clk`
  - `hsync`=`vsync`=1 throughout reset
- Run one full line:
  - `video_on` falls when `pixel_x` goes 639→640
  - `hsync` low for exactly 96 pix_en steps (`pixel_x` 656..751)
  - `line_start` at `pixel_x`=0 every 800 steps (1600 `clk`)
- Run one full frame:
  - `vsync` low for exactly 2 lines (`pixel_y` 490..491), edges coincident with `pixel_x`=0
  - `frame_start` period = 420 000 `pix_en` steps
  - `pixel_y` never exceeds 524
- Hold `pix_en`=0 for 100 `clk` mid-line at `pixel_x`=300: all outputs frozen, no `line_start` pulse; resumes at `pixel_x`=301.
- Assert `clr` asynchronously (between `clk` edges) at `pixel_x`=700, `pixel_y`=490, while `hsync`=0 and `vsync`=0:
  - outputs immediately return to 799/524, `hsync`=1, `vsync`=1, `video_on`=0
  - after release, the next `pix_en` gives (0,0) with `frame_start`.
- `pix_en` tied high: `frame_start` period = 420 000 `clk`; a scoreboard confirms every `hsync`/`vsync`/`video_on` value against a reference counter model.

Source files
------------

// File: rtl/vga_sync.sv
// VGA sync/position counters stepped by pix_en; outputs registered, decoded from the next count (0-cycle latency).
// No backpressure: pix_en=0 freezes counters and level outputs, and clears the start pulses.
module vga_sync #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Decodes use the next count so each level output lines up with the counter it describes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync       <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      video_on    <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: reference position model feeds a scoreboard queue.
// Vertical timing is shrunk to 12 lines (6 visible, sync on lines 8..9) so whole frames fit a short run.
module tb_vga_sync;

  logic       clk;
  logic       clr;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mx;
  int my;
  logic [24:0] sb_q[$];

  vga_sync #(
    .V_VIS (6),
    .V_FP  (2),
    .V_SYNC(2),
    .V_BP  (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one clk of pix_en, advance the model, then compare DUT against the queued expectation.
  task automatic tick(input logic en);
    logic ls, fs, hs, vs, vo;
    logic [24:0] obs;
    pix_en = en;
    ls = 1'b0;
    fs = 1'b0;
    if (en) begin
      if (mx == 799) begin
        ls = 1'b1;
        mx = 0;
        if (my == 11) begin
          fs = 1'b1;
          my = 0;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end
    hs = !(mx >= 656 && mx <= 751);
    vs = !(my >= 8 && my <= 9);
    vo = (mx < 640) && (my < 6);
    sb_q.push_back({10'(mx), 10'(my), hs, vs, vo, ls, fs});
    @(posedge clk);
    #1;
    obs = {pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start};
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("sb", 32'(obs), 32'(sb_q.pop_front()));
  endtask

  initial begin
    int hs_low_l0, ln_cnt, vs_lines, fs_step, max_y, vs_bad, ls_gap_bad, last_ls;
    int vo_fall_x, pause_ls, c0, fs_period, fs_cnt;
    logic prev_vs, prev_vo;

    clr = 1'b1;
    pix_en = 1'b0;
    mx = 799;
    my = 11;
    #2 clr = 1'b0;
    #1;
    chk("rst_x", 32'(pixel_x), 32'd799);
    chk("rst_y", 32'(pixel_y), 32'd11);
    chk("rst_sync", 32'({hsync, vsync}), 32'b11);
    chk("rst_vo_ls_fs", 32'({video_on, line_start, frame_start}), 32'b000);

    // pix_en active while held in reset must not move anything.
    pix_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'({pixel_x, pixel_y, hsync, vsync, video_on}), 32'({10'd799, 10'd11, 3'b110}));
    end
    pix_en = 1'b0;
    #5 clr = 1'b1;

    tick(1'b1);
    chk("first_xy", 32'({pixel_x, pixel_y}), 32'd0);
    chk("first_vo_fs", 32'({video_on, line_start, frame_start}), 32'b111);
    tick(1'b0);
    chk("fs_width", 32'(frame_start), 32'd0);

    // One full frame with pix_en alternating.
    hs_low_l0 = 0; ln_cnt = 0; vs_lines = 0; fs_step = -1; max_y = 0; vs_bad = 0;
    ls_gap_bad = 0; last_ls = 0; vo_fall_x = -1;
    prev_vs = vsync;
    prev_vo = video_on;
    for (int step = 1; step <= 9600; step++) begin
      tick(1'b1);
      if (my == 0 && !hsync) hs_low_l0++;
      if (prev_vo && !video_on && vo_fall_x < 0) vo_fall_x = int'(pixel_x);
      if (vsync != prev_vs && pixel_x != 10'd0) vs_bad++;
      if (line_start) begin
        ln_cnt++;
        if (!vsync) vs_lines++;
        if (step - last_ls != 800) ls_gap_bad++;
        last_ls = step;
      end
      if (frame_start) fs_step = step;
      if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
      prev_vs = vsync;
      prev_vo = video_on;
      tick(1'b0);
    end
    chk("hsync_low_steps", 32'(hs_low_l0), 32'd96);
    chk("vo_fall_x", 32'(vo_fall_x), 32'd640);
    chk("line_cnt", 32'(ln_cnt), 32'd12);
    chk("line_gap", 32'(ls_gap_bad), 32'd0);
    chk("vsync_lines", 32'(vs_lines), 32'd2);
    chk("vsync_mid_line", 32'(vs_bad), 32'd0);
    chk("frame_period", 32'(fs_step), 32'd9600);
    chk("max_y", 32'(max_y), 32'd11);

    // Pause mid-line.
    for (int i = 0; i < 300; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("pause_at", 32'(pixel_x), 32'd300);
    pause_ls = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      if (line_start) pause_ls++;
    end
    chk("pause_no_ls", 32'(pause_ls), 32'd0);
    tick(1'b1);
    chk("resume_x", 32'(pixel_x), 32'd301);
    tick(1'b0);

    // Walk into the sync region, then reset between clock edges.
    for (int i = 0; i < 6799; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("pre_rst_xy", 32'({pixel_x, pixel_y}), 32'({10'd700, 10'd8}));
    chk("pre_rst_sync", 32'({hsync, vsync}), 32'b00);
    #5 clr = 1'b0;
    #1;
    chk("arst_xy", 32'({pixel_x, pixel_y}), 32'({10'd799, 10'd11}));
    chk("arst_out", 32'({hsync, vsync, video_on, line_start, frame_start}), 32'b11000);
    mx = 799;
    my = 11;
    #5 clr = 1'b1;
    tick(1'b1);
    chk("restart_xy", 32'({pixel_x, pixel_y}), 32'd0);
    chk("restart_fs", 32'({line_start, frame_start}), 32'b11);

    // pix_en tied high: one frame is 9600 clk.
    c0 = cyc;
    fs_period = -1;
    fs_cnt = 0;
    for (int i = 0; i < 9600; i++) begin
      tick(1'b1);
      if (frame_start) begin
        fs_cnt++;
        fs_period = cyc - c0;
      end
    end
    chk("tied_fs_cnt", 32'(fs_cnt), 32'd1);
    chk("tied_fs_period", 32'(fs_period), 32'd9600);
    tick(1'b0);
    chk("tied_fs_drop", 32'(frame_start), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
